// File: rtl/hdm_pkg.sv
// Shared types and width helper for the frame accumulator.
package hdm_pkg;

  typedef enum logic [0:0] {ACCUM, EMIT} hdm_state_e;

  // Width of a frame sum: one extra bit per doubling of the frame length.
  function automatic int sum_w(input int data_w, input int frame_len);
    return data_w + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/hdm_frame_accum.sv
// Frame accumulator: sums FRAME_LEN handshaked samples (or a flushed partial
// frame) and presents each sum over a valid/ready output.
// Optional macro HDM_ODD_CHECK_EN adds out_err, flagging frames that contained
// an even sample (the upstream 2*in+1 stage only ever produces odd values).
module hdm_frame_accum
  import hdm_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  localparam int SUM_W    = sum_w(DATA_W, FRAME_LEN),
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
`ifdef HDM_ODD_CHECK_EN
  output logic              out_err,
`endif
  output logic [CNT_W-1:0]  out_count
);

  hdm_state_e       state, state_n;
  logic [SUM_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             accept, close;
`ifdef HDM_ODD_CHECK_EN
  logic             err, err_n;
`endif

  // Next state, in_ready, and the post-accept running totals used on close.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    close    = 1'b0;
    acc_n    = acc;
    cnt_n    = cnt;
`ifdef HDM_ODD_CHECK_EN
    err_n    = err;
`endif
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          acc_n = acc + SUM_W'(in_data);
          cnt_n = cnt + 1'b1;
`ifdef HDM_ODD_CHECK_EN
          err_n = err | ~in_data[0];
`endif
        end
        // A flush on the final accept closes just the one full frame.
        close = (accept && cnt_n == CNT_W'(FRAME_LEN)) ||
                (flush && cnt_n != '0);
        if (close) state_n = EMIT;
      end
      EMIT: begin
        if (out_ready) state_n = ACCUM;
      end
      default: state_n = ACCUM;
    endcase
  end

  // Frame registers: accumulate, latch result on close, hold through EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
`ifdef HDM_ODD_CHECK_EN
      err       <= 1'b0;
      out_err   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == ACCUM) begin
        if (close) begin
          out_valid <= 1'b1;
          out_sum   <= acc_n;
          out_count <= cnt_n;
          acc       <= '0;
          cnt       <= '0;
`ifdef HDM_ODD_CHECK_EN
          out_err   <= err_n;
          err       <= 1'b0;
`endif
        end else begin
          acc <= acc_n;
          cnt <= cnt_n;
`ifdef HDM_ODD_CHECK_EN
          err <= err_n;
`endif
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdm_frame_accum.sv
// Directed bench for hdm_frame_accum (DATA_W=8, FRAME_LEN=4).
module tb_hdm_frame_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] out_sum;
  logic [2:0] out_count;
`ifdef HDM_ODD_CHECK_EN
  logic       out_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  hdm_frame_accum #(.DATA_W(8), .FRAME_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum),
`ifdef HDM_ODD_CHECK_EN
    .out_err(out_err),
`endif
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present samples back-to-back; leaves in_valid low after the last accept.
  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    logic [7:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sum",   32'(out_sum),   0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_in_ready",  32'(in_ready),  1);
    rst_n = 1'b1;
    step();

    // 1) 1,3,5,7 back-to-back -> 16 one cycle after 4th accept, valid for 1 cycle
    send4(8'd1, 8'd3, 8'd5, 8'd7);
    check("t1_valid",    32'(out_valid), 1);
    check("t1_sum",      32'(out_sum),   16);
    check("t1_count",    32'(out_count), 4);
    check("t1_in_ready", 32'(in_ready),  0);
    step();
    check("t1_valid_drop", 32'(out_valid), 0);
    check("t1_ready_back", 32'(in_ready),  1);

    // 2) four 0xFF -> 1020, no wrap
    send4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("t2_sum",   32'(out_sum),   1020);
    check("t2_count", 32'(out_count), 4);
    step();

    // 3) backpressure for 5 cycles while upstream keeps offering 7
    out_ready = 1'b0;
    send4(8'd1, 8'd1, 8'd1, 8'd1);
    in_valid = 1'b1;
    in_data  = 8'd7;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(out_valid), 1);
      check("t3_hold_sum",   32'(out_sum),   4);
      check("t3_hold_ready", 32'(in_ready),  0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("t3_released_valid", 32'(out_valid), 0);
    check("t3_released_ready", 32'(in_ready),  1);
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    check("t3_next_sum",   32'(out_sum),   7);
    check("t3_next_count", 32'(out_count), 1);
    step();

    // 4) 9,11 then flush -> 20/2; flush on empty frame -> nothing
    in_valid = 1'b1; in_data = 8'd9;  step();
    in_data  = 8'd11; step();
    in_valid = 1'b0;
    check("t4_no_early", 32'(out_valid), 0);
    flush = 1'b1; step(); flush = 1'b0;
    check("t4_valid", 32'(out_valid), 1);
    check("t4_sum",   32'(out_sum),   20);
    check("t4_count", 32'(out_count), 2);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    check("t4_empty_flush", 32'(out_valid), 0);
    step();
    check("t4_empty_flush2", 32'(out_valid), 0);

    // 4b) flush together with the 4th accept -> single full frame
    in_valid = 1'b1; in_data = 8'd2;
    step(); step(); step();
    flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("t4b_sum",   32'(out_sum),   8);
    check("t4b_count", 32'(out_count), 4);
    step();
    step();
    check("t4b_no_extra", 32'(out_valid), 0);

    // 5) async reset after 3 accepts discards the partial frame
    in_valid = 1'b1; in_data = 8'd5;
    step(); step(); step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 0);
    check("t5_rst_sum",   32'(out_sum),   0);
    check("t5_rst_count", 32'(out_count), 0);
    check("t5_rst_ready", 32'(in_ready),  1);
    #3 rst_n = 1'b1;
    step();
    send4(8'd1, 8'd1, 8'd1, 8'd1);
    check("t5_sum",   32'(out_sum),   4);
    check("t5_count", 32'(out_count), 4);
    step();

`ifdef HDM_ODD_CHECK_EN
    // 6) even sample marks the frame; next clean frame clears it
    send4(8'd1, 8'h10, 8'd3, 8'd5);
    check("t6_err", 32'(out_err), 1);
    check("t6_sum", 32'(out_sum), 25);
    step();
    send4(8'd1, 8'd1, 8'd1, 8'd1);
    check("t6_clean_err", 32'(out_err), 0);
    check("t6_clean_sum", 32'(out_sum), 4);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
